operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode/operand-fetch pipeline stage sitting directly upstream of the integer register file.
- Extracts rs1/rs2/rd from the incoming instruction and drives the register-file read addresses combinationally.
- Bypasses same-cycle writeback data and tracks outstanding load destinations in a scoreboard.
- Registers the instruction with its resolved operands into a valid/ready output slot that feeds execute.

Parameters:
XLEN, 32, datapath width of pc, instruction and operand fields
BYPASS_EN, 1, 1 = forward wb_data to operands on an address match; 0 = stall on the match instead

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_pc  input  XLEN  pc of the incoming instruction
in_inst  input  32  raw RV32I instruction
rs1_addr  output  5  register-file read address 1 (in_inst[19:15])
rs2_addr  output  5  register-file read address 2 (in_inst[24:20])
rs1_data  input  XLEN  register-file read data 1
rs2_data  input  XLEN  register-file read data 2
is_write  input  1  writeback strobe (shared with register file)
wb_addr  input  5  writeback destination
wb_data  input  XLEN  writeback data
flush  input  1  discard the held output and do not accept an instruction this cycle
out_valid  output  1  execute slot holds an instruction
out_ready  input  1  execute consumes the slot
out_pc  output  XLEN  registered pc
out_inst  output  32  registered instruction
out_rs1  output  XLEN  resolved operand 1
out_rs2  output  XLEN  resolved operand 2
out_rd  output  5  destination (in_inst[11:7])

Behaviour:
- Reset (reset==0, asynchronous): out_valid=0; out_pc, out_inst, out_rs1, out_rs2 = 0; out_rd=0; scoreboard busy[31:1]=0. in_ready is combinational and follows these register values.
- Register reads: rs1_addr and rs2_addr are combinational from in_inst regardless of in_valid. Read data is sampled in the same cycle.
- Operand use, by opcode in_inst[6:0]:
  - LUI/AUIPC/JAL: use neither operand.
  - JALR/LOAD/OP-IMM: use rs1 only.
  - BRANCH/STORE/OP: use rs1 and rs2.
  - Any other opcode: treated as using no operand.
  - Address x0 never counts as used.
- Bypass (BYPASS_EN=1): if is_write, wb_addr!=0 and wb_addr==rsN_addr, the operand is wb_data; otherwise it is rsN_data. With BYPASS_EN=0 this match is a hazard instead.
- Scoreboard busy[r]:
  - Set on an accepted LOAD with rd!=0.
  - Cleared when is_write and wb_addr==r.
  - Same-cycle set and clear of the same r: set wins.
  - busy[0] is constant 0.
- Hazard: a used operand whose busy bit is set and is not cleared this cycle.
  - A busy operand written back this cycle is bypassed, not stalled (BYPASS_EN=1).
- Handshake: in_ready = ~flush & ~hazard & (~out_valid | out_ready). Accept = in_valid & in_ready.
- Output slot update:
  - Accept: load pc/inst/operands/rd; out_valid=1. Latency is 1 cycle from accept to out_valid.
  - Else if out_ready, or flush: out_valid=0.
  - While out_valid & ~out_ready, all out_* are held stable.
- Flush:
  - Clears out_valid next cycle.
  - Blocks accept in the same cycle.
  - Does NOT clear the scoreboard: issued loads still write back and clear their bits.
- Back-to-back: full throughput of one instruction per cycle when there is no hazard and out_ready=1.
- Reset asserted mid-stall: the slot and scoreboard clear immediately; after release, the first instruction is accepted with no residual hazard.

Test Plan:
1. After reset release, present ADDI x1,x0,5 (0x00500093) with out_ready=1 -> in_ready=1; next cycle out_valid=1, out_rd=1, out_rs1=0.
2. ADD x3,x1,x2 with rs1_data=0x10, rs2_data=0x20 and same-cycle is_write, wb_addr=2, wb_data=0x99 -> out_rs1=0x10, out_rs2=0x99. With BYPASS_EN=0 -> in_ready=0 that cycle.
3. Accept LW x5,0(x0), then present ADD x6,x5,x5 -> in_ready=0 until is_write, wb_addr=5, wb_data=0xABCD. In that cycle accept occurs with out_rs1=out_rs2=0xABCD; busy[5]=0 afterwards.
4. Hold out_ready=0 with out_valid=1 for 3 cycles while presenting a new instruction -> in_ready=0 and out_* unchanged. Then out_ready=1 -> new instruction accepted; out_valid stays 1 with the new pc.
5. Assert flush with in_valid=1 and out_valid=1 -> no accept; out_valid=0 next cycle. Any busy bit from an earlier load remains set until its writeback.
6. Drop reset to 0 while busy[7]=1 and out_valid=1 -> out_valid=0 and busy=0 immediately. After release, ADD x8,x7,x0 is accepted on the first cycle.

Source files
------------

// File: rtl/operand_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// operand_fetch : decode/operand-fetch stage with writeback bypass, load
//                 scoreboard and a valid/ready output slot.   Rev 1.0
// ----------------------------------------------------------------------------
module operand_fetch #(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            is_write,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [4:0]      out_rd
);

  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [31:0]     r_out_inst;
  logic [XLEN-1:0] r_out_rs1;
  logic [XLEN-1:0] r_out_rs2;
  logic [4:0]      r_out_rd;
  logic [31:0]     r_busy;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic            w_use1_op, w_use2_op;
  logic            w_use1, w_use2;
  logic            w_wb_hit1, w_wb_hit2;
  logic            w_busy1, w_busy2;
  logic            w_haz1, w_haz2;
  logic            w_hazard;
  logic            w_accept;
  logic [31:0]     w_clr;
  logic [31:0]     w_set;
  logic [XLEN-1:0] w_op1, w_op2;

  assign w_opcode = in_inst[6:0];
  assign w_rd     = in_inst[11:7];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  // LUI/AUIPC/JAL and unknown opcodes read no register.
  always_comb begin
    w_use1_op = 1'b0;
    w_use2_op = 1'b0;
    case (w_opcode)
      c_OP_JALR, c_OP_LOAD, c_OP_IMM: w_use1_op = 1'b1;
      c_OP_BRANCH, c_OP_STORE, c_OP_OP: begin
        w_use1_op = 1'b1;
        w_use2_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_use1 = w_use1_op & (rs1_addr != 5'd0);
  assign w_use2 = w_use2_op & (rs2_addr != 5'd0);

  assign w_wb_hit1 = is_write & (wb_addr != 5'd0) & (wb_addr == rs1_addr);
  assign w_wb_hit2 = is_write & (wb_addr != 5'd0) & (wb_addr == rs2_addr);

  assign w_clr = is_write ? (32'd1 << wb_addr) : 32'd0;
  assign w_set = (w_accept && (w_opcode == c_OP_LOAD) && (w_rd != 5'd0)) ? (32'd1 << w_rd) : 32'd0;

  // A busy register being written back this cycle is not a scoreboard stall.
  assign w_busy1 = r_busy[rs1_addr] & ~w_clr[rs1_addr];
  assign w_busy2 = r_busy[rs2_addr] & ~w_clr[rs2_addr];

  assign w_haz1   = w_use1 & (w_busy1 | (~BYPASS_EN & w_wb_hit1));
  assign w_haz2   = w_use2 & (w_busy2 | (~BYPASS_EN & w_wb_hit2));
  assign w_hazard = w_haz1 | w_haz2;

  assign w_op1 = (BYPASS_EN && w_wb_hit1) ? wb_data : rs1_data;
  assign w_op2 = (BYPASS_EN && w_wb_hit2) ? wb_data : rs2_data;

  assign in_ready = ~flush & ~w_hazard & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_rd    <= '0;
      r_busy      <= '0;
    end else begin
      // Set is applied after clear so a same-cycle load issue wins.
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= in_pc;
        r_out_inst  <= in_inst;
        r_out_rs1   <= w_op1;
        r_out_rs2   <= w_op2;
        r_out_rd    <= w_rd;
      end else if (out_ready || flush) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;
  assign out_rs1   = r_out_rs1;
  assign out_rs2   = r_out_rs2;
  assign out_rd    = r_out_rd;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// Bench for operand_fetch: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the stage.
module tb_operand_fetch;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, in_valid, is_write, flush, out_ready;
  logic [XLEN-1:0] in_pc, rs1_data, rs2_data, wb_data;
  logic [31:0]     in_inst;
  logic [4:0]      wb_addr;

  logic            in_ready, out_valid;
  logic [4:0]      rs1_addr, rs2_addr, out_rd;
  logic [XLEN-1:0] out_pc, out_rs1, out_rs2;
  logic [31:0]     out_inst;

  logic            b0_in_ready, b0_out_valid;
  logic [4:0]      b0_rs1_addr, b0_rs2_addr, b0_out_rd;
  logic [XLEN-1:0] b0_out_pc, b0_out_rs1, b0_out_rs2;
  logic [31:0]     b0_out_inst;

  operand_fetch #(.XLEN(XLEN), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .is_write(is_write),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd));

  operand_fetch #(.XLEN(XLEN), .BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b0_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(b0_rs1_addr), .rs2_addr(b0_rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .is_write(is_write),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(b0_out_valid), .out_ready(out_ready), .out_pc(b0_out_pc),
    .out_inst(b0_out_inst), .out_rs1(b0_out_rs1), .out_rs2(b0_out_rs2), .out_rd(b0_out_rd));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the execute slot and the set of registers awaiting a load.
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_rs1, m_rs2;
  logic [31:0]     m_inst;
  logic [4:0]      m_rd;
  bit              m_busy [32];
  logic [XLEN-1:0] pc_ctr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [31:0] inst, input int which);
    logic [6:0] op = inst[6:0];
    logic [4:0] a  = (which == 1) ? inst[19:15] : inst[24:20];
    bit u;
    case (op)
      7'h67, 7'h03, 7'h13: u = (which == 1);
      7'h63, 7'h23, 7'h33: u = 1'b1;
      default:             u = 1'b0;
    endcase
    return u && (a != 5'd0);
  endfunction

  function automatic bit waits_on(input logic [4:0] a, input bit used);
    return used && m_busy[a] && !(is_write && wb_addr == a);
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] a, input logic [XLEN-1:0] rf);
    return (is_write && wb_addr != 5'd0 && wb_addr == a) ? wb_data : rf;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic check_out();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_pc",    out_pc,   m_pc);
    check("out_inst",  out_inst, m_inst);
    check("out_rs1",   out_rs1,  m_rs1);
    check("out_rs2",   out_rs2,  m_rs2);
    check("out_rd",    32'(out_rd), 32'(m_rd));
  endtask

  // One clock: check combinational outputs mid-cycle, then the slot after the edge.
  task automatic tick(output bit rdy);
    bit exp_ready, acc;
    logic [4:0] a1, a2;
    #1;
    a1 = in_inst[19:15];
    a2 = in_inst[24:20];
    exp_ready = !flush && !waits_on(a1, reads_reg(in_inst, 1)) &&
                !waits_on(a2, reads_reg(in_inst, 2)) && (!m_valid || out_ready);
    rdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("rs1_addr", 32'(rs1_addr), 32'(a1));
    check("rs2_addr", 32'(rs2_addr), 32'(a2));
    acc = in_valid && exp_ready;
    @(posedge clk);
    if (is_write) m_busy[wb_addr] = 1'b0;
    if (acc) begin
      m_valid = 1'b1; m_pc = in_pc; m_inst = in_inst; m_rd = in_inst[11:7];
      m_rs1 = operand(a1, rs1_data);
      m_rs2 = operand(a2, rs2_data);
      if (in_inst[6:0] == 7'h03 && in_inst[11:7] != 5'd0) m_busy[in_inst[11:7]] = 1'b1;
    end else if (out_ready || flush) begin
      m_valid = 1'b0;
    end
    m_busy[0] = 1'b0;
    #1;
    check_out();
  endtask

  task automatic put(input logic [31:0] inst, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    in_valid = 1'b1; in_inst = inst; in_pc = pc_ctr; pc_ctr += 4;
    rs1_data = d1; rs2_data = d2;
  endtask

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] ADD_X3  = 32'h0020_81B3;
  localparam logic [31:0] LW_X5   = 32'h0000_2283;
  localparam logic [31:0] ADD_X6  = 32'h0052_8333;
  localparam logic [31:0] LW_X9   = 32'h0000_2483;
  localparam logic [31:0] ADD_X10 = 32'h0004_8533;
  localparam logic [31:0] LW_X7   = 32'h0000_2383;
  localparam logic [31:0] ADD_X8  = 32'h0003_8433;

  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h7F};

  initial begin
    bit rdy;
    logic [XLEN-1:0] saved_pc, new_pc;
    logic [31:0] r;

    reset = 1'b0; in_valid = 1'b0; is_write = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0; rs1_data = '0; rs2_data = '0; wb_addr = '0; wb_data = '0;
    pc_ctr = 32'h1000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out();
    reset = 1'b1;

    // ADDI x1,x0,5
    put(ADDI_X1, '0, '0);
    tick(rdy);
    check("t1_ready", 32'(rdy), 32'd1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_rd", 32'(out_rd), 32'd1);
    check("t1_rs1", out_rs1, 32'h0);

    // ADD x3,x1,x2 with same-cycle writeback of x2
    put(ADD_X3, 32'h10, 32'h20);
    is_write = 1'b1; wb_addr = 5'd2; wb_data = 32'h99;
    #1;
    check("t2_nobypass_ready", 32'(b0_in_ready), 32'd0);
    tick(rdy);
    check("t2_rs1", out_rs1, 32'h10);
    check("t2_rs2", out_rs2, 32'h99);
    is_write = 1'b0;

    // Load-use stall resolved by the load's writeback
    put(LW_X5, '0, '0);
    tick(rdy);
    check("t3_lw_ready", 32'(rdy), 32'd1);
    put(ADD_X6, '0, '0);
    repeat (2) begin
      tick(rdy);
      check("t3_stall", 32'(rdy), 32'd0);
    end
    is_write = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    tick(rdy);
    check("t3_wb_ready", 32'(rdy), 32'd1);
    check("t3_rs1", out_rs1, 32'hABCD);
    check("t3_rs2", out_rs2, 32'hABCD);
    is_write = 1'b0;
    put(ADD_X6, 32'h1, 32'h2);
    tick(rdy);
    check("t3_busy_clear", 32'(rdy), 32'd1);

    // Backpressure holds the slot
    out_ready = 1'b0;
    saved_pc = out_pc;
    put(ADDI_X1, '0, '0);
    new_pc = in_pc;
    repeat (3) begin
      tick(rdy);
      check("t4_hold_ready", 32'(rdy), 32'd0);
      check("t4_hold_pc", out_pc, saved_pc);
    end
    out_ready = 1'b1;
    tick(rdy);
    check("t4_ready", 32'(rdy), 32'd1);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_pc", out_pc, new_pc);

    // Flush with an outstanding load
    put(LW_X9, '0, '0);
    tick(rdy);
    flush = 1'b1;
    put(ADDI_X1, '0, '0);
    tick(rdy);
    check("t5_flush_ready", 32'(rdy), 32'd0);
    check("t5_flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    put(ADD_X10, '0, '0);
    tick(rdy);
    check("t5_busy_kept", 32'(rdy), 32'd0);
    is_write = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick(rdy);
    check("t5_wb_ready", 32'(rdy), 32'd1);
    check("t5_rs1", out_rs1, 32'h55);
    is_write = 1'b0;

    // Reset in the middle of a load-use stall
    put(LW_X7, '0, '0);
    tick(rdy);
    out_ready = 1'b0;
    put(ADD_X8, '0, '0);
    tick(rdy);
    check("t6_stall", 32'(rdy), 32'd0);
    check("t6_valid_before", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check("t6_valid_async", 32'(out_valid), 32'd0);
    check_out();
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    tick(rdy);
    check("t6_ready_after", 32'(rdy), 32'd1);
    check("t6_rd", 32'(out_rd), 32'd8);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      r[6:0]   = ops[$urandom_range(0, 9)];
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      put(r, $urandom(), $urandom());
      in_valid  = ($urandom_range(0, 9) < 8);
      is_write  = ($urandom_range(0, 9) < 4);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom();
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick(rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
